// File: rtl/grid_overlay.sv
// Cell-grid border and cursor-cell overlay for the VGA pixel pipeline, two-stage registered.
// Optional macro GRID_BLINK_EN: blinks the cursor using a frame counter.
module grid_overlay #(
    parameter int unsigned CELL_LOG2  = 5,
    parameter int unsigned EDGE_W     = 2,
    parameter int unsigned IDX_W      = 6,
    parameter logic [11:0] EDGE_RGB   = 12'h000,
    parameter logic [11:0] HL_RGB     = 12'hF00,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      hcount_in,
    input  logic [15:0]      vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [11:0]      rgb_in,
    input  logic             grid_en,
    input  logic [IDX_W-1:0] cur_col,
    input  logic [IDX_W-1:0] cur_row,
    input  logic             cur_on,
    input  logic             cur_load,
    output logic             cur_busy,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [11:0]      rgb_out
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned CELL_SIZE = 1 << CELL_LOG2;
    localparam int unsigned IDX_HI    = CELL_LOG2 + IDX_W;

    logic [CELL_LOG2-1:0] s1_x_off;
    logic [CELL_LOG2-1:0] s1_y_off;
    logic [IDX_W-1:0]     s1_col;
    logic [IDX_W-1:0]     s1_row;
    logic [11:0]          s1_rgb;
    logic                 s1_hsync;
    logic                 s1_vsync;
    logic                 s1_grid_en;

    logic                 vsync_prev;
    logic [IDX_W-1:0]     pend_col;
    logic [IDX_W-1:0]     pend_row;
    logic                 pend_on;
    logic [IDX_W-1:0]     act_col;
    logic [IDX_W-1:0]     act_row;
    logic                 act_on;

    logic                 frame_start_c;
    logic                 blink_vis_c;
    logic                 edge_hit_c;
    logic                 cur_hit_c;
    logic [11:0]          pix_c;
    logic                 unused_bits_c;

    assign unused_bits_c = ^{hcount_in[CNT_W-1:IDX_HI], vcount_in[CNT_W-1:IDX_HI]};
    assign frame_start_c = vsync_in & ~vsync_prev;

    // Stage 1: split coordinates into cell index and in-cell offset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_x_off   <= '0;
            s1_y_off   <= '0;
            s1_col     <= '0;
            s1_row     <= '0;
            s1_rgb     <= '0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_grid_en <= 1'b0;
        end else begin
            s1_x_off   <= hcount_in[CELL_LOG2-1:0];
            s1_y_off   <= vcount_in[CELL_LOG2-1:0];
            s1_col     <= hcount_in[IDX_HI-1:CELL_LOG2];
            s1_row     <= vcount_in[IDX_HI-1:CELL_LOG2];
            s1_rgb     <= rgb_in;
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
            s1_grid_en <= grid_en;
        end
    end

    // Pending register takes loads any time; active copy only moves at frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev <= 1'b0;
            pend_col   <= '0;
            pend_row   <= '0;
            pend_on    <= 1'b0;
            act_col    <= '0;
            act_row    <= '0;
            act_on     <= 1'b0;
            cur_busy   <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (frame_start_c && cur_busy) begin
                act_col <= pend_col;
                act_row <= pend_row;
                act_on  <= pend_on;
            end
            if (cur_load) begin
                pend_col <= cur_col;
                pend_row <= cur_row;
                pend_on  <= cur_on;
                cur_busy <= 1'b1;
            end else if (frame_start_c) begin
                cur_busy <= 1'b0;
            end
        end
    end

`ifdef GRID_BLINK_EN
    localparam int unsigned FRAME_W = BLINK_LOG2 + 1;

    logic [FRAME_W-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start_c) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    assign blink_vis_c = ~frame_cnt[BLINK_LOG2];
`else
    localparam int unsigned unused_blink_log2 = BLINK_LOG2;

    assign blink_vis_c = 1'b1;
`endif

    // Border test stays inside the cell, so neighbouring cells form a 2*EDGE_W line
    always_comb begin
        edge_hit_c = 1'b0;
        cur_hit_c  = 1'b0;
        pix_c      = s1_rgb;
        edge_hit_c = s1_grid_en &&
                     ((32'(s1_x_off) < EDGE_W) || (32'(s1_x_off) >= CELL_SIZE - EDGE_W) ||
                      (32'(s1_y_off) < EDGE_W) || (32'(s1_y_off) >= CELL_SIZE - EDGE_W));
        cur_hit_c  = act_on && (s1_col == act_col) && (s1_row == act_row) && blink_vis_c;
        if (edge_hit_c) begin
            pix_c = EDGE_RGB;
        end else if (cur_hit_c) begin
            pix_c = HL_RGB;
        end
    end

    // Stage 2: composited pixel and matching sync delay
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb_out   <= pix_c;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
        end
    end

endmodule
